// File: rtl/load_unit_cache_control_if.sv
// Signal bundle between the read-side cache controller and its
// load unit, cache arrays, eviction path and memory port.
interface load_unit_cache_control_if;
  logic        load_req_i;
  logic [31:0] load_address_i;
  logic [1:0]  load_width_i;
  logic        load_signed_i;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        idle_o;
  logic        cache_hit_i;
  logic        cache_dirty_i;
  logic [31:0] cache_data_i;
  logic        cache_read_o;
  logic        cache_write_o;
  logic [31:0] cache_address_o;
  logic [31:0] cache_data_o;
  logic        cache_valid_o;
  logic        cache_dirty_o;
  logic [3:0]  cache_enable_o;
  logic        evict_req_o;
  logic [31:0] evict_address_o;
  logic        evict_done_i;
  logic        mem_req_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_i;
  logic        mem_data_valid_i;

  modport slave (
    input  load_req_i, load_address_i,
    input  load_width_i, load_signed_i,
    output load_data_o, load_valid_o, idle_o,
    input  cache_hit_i, cache_dirty_i,
    input  cache_data_i,
    output cache_read_o, cache_write_o,
    output cache_address_o, cache_data_o,
    output cache_valid_o, cache_dirty_o,
    output cache_enable_o,
    output evict_req_o, evict_address_o,
    input  evict_done_i,
    output mem_req_o, mem_address_o,
    input  mem_data_i, mem_data_valid_i
  );

  modport master (
    output load_req_i, load_address_i,
    output load_width_i, load_signed_i,
    input  load_data_o, load_valid_o, idle_o,
    output cache_hit_i, cache_dirty_i,
    output cache_data_i,
    input  cache_read_o, cache_write_o,
    input  cache_address_o, cache_data_o,
    input  cache_valid_o, cache_dirty_o,
    input  cache_enable_o,
    input  evict_req_o, evict_address_o,
    output evict_done_i,
    input  mem_req_o, mem_address_o,
    output mem_data_i, mem_data_valid_i
  );
endinterface

// File: rtl/load_unit_cache_control.sv
// Read-side data-cache controller: tag compare, victim hand-off,
// word-by-word block refill and aligned/extended load return.
module load_unit_cache_control #(
  parameter int PORT_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int INDEX_BITS  = 8
) (
  input logic clk_i,
  input logic rst_n_i,
  load_unit_cache_control_if.slave bus
);
  localparam int OFS      = $clog2(BLOCK_WORDS);
  localparam int TLO      = OFS + 2 + INDEX_BITS;
  localparam int TAG_BITS = 32 - TLO;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE_TAG,
    S_EVICT_WAIT,
    S_MEM_REQUEST,
    S_ALLOCATE,
    S_RESPOND
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_addr;
  logic [1:0]            r_width;
  logic                  r_signed;
  logic [OFS-1:0]        r_cnt;
  logic [PORT_WIDTH-1:0] r_word;
  logic                  w_accept;
  logic                  w_beat;

  function automatic logic [31:0] align(
    input logic [31:0] w,
    input logic [1:0]  sel,
    input logic [1:0]  width,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{sel, 3'b000} +: 8];
    h = sel[1] ? w[31:16] : w[15:0];
    case (width)
      2'b00:   align = {{24{sgn & b[7]}}, b};
      2'b01:   align = {{16{sgn & h[15]}}, h};
      default: align = w;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_width  <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_word   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= bus.load_address_i;
        r_width  <= bus.load_width_i;
        r_signed <= bus.load_signed_i;
      end
      if (r_state == S_MEM_REQUEST) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == r_addr[OFS+1:2])
          r_word <= bus.mem_data_i;
      end
    end
  end

  always_comb begin
    w_next              = r_state;
    w_accept            = 1'b0;
    w_beat              = 1'b0;
    bus.idle_o          = (r_state == S_IDLE);
    bus.load_data_o     = '0;
    bus.load_valid_o    = 1'b0;
    bus.cache_read_o    = 1'b0;
    bus.cache_write_o   = 1'b0;
    bus.cache_address_o = '0;
    bus.cache_data_o    = '0;
    bus.cache_valid_o   = 1'b0;
    bus.cache_dirty_o   = 1'b0;
    bus.cache_enable_o  = 4'b0000;
    bus.evict_req_o     = 1'b0;
    bus.evict_address_o = '0;
    bus.mem_req_o       = 1'b0;
    bus.mem_address_o   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.load_req_i) begin
          w_accept            = 1'b1;
          bus.cache_read_o    = 1'b1;
          bus.cache_enable_o  = 4'b1111;
          bus.cache_address_o = {{TAG_BITS{1'b0}},
                                 bus.load_address_i[TLO-1:2],
                                 2'b00};
          w_next              = S_COMPARE_TAG;
        end
      end
      S_COMPARE_TAG: begin
        bus.cache_address_o = {r_addr[31:2], 2'b00};
        if (bus.cache_hit_i) begin
          bus.load_valid_o = 1'b1;
          bus.load_data_o  = align(bus.cache_data_i, r_addr[1:0],
                                   r_width, r_signed);
          w_next           = S_IDLE;
        end else if (bus.cache_dirty_i) begin
          w_next = S_EVICT_WAIT;
        end else begin
          w_next = S_MEM_REQUEST;
        end
      end
      S_EVICT_WAIT: begin
        // eviction unit supplies the victim tag from its own read
        bus.evict_req_o     = 1'b1;
        bus.evict_address_o = {{TAG_BITS{1'b0}},
                               r_addr[TLO-1:OFS+2],
                               {(OFS+2){1'b0}}};
        if (bus.evict_done_i)
          w_next = S_MEM_REQUEST;
      end
      S_MEM_REQUEST: begin
        bus.mem_req_o     = 1'b1;
        bus.mem_address_o = {r_addr[31:OFS+2], {(OFS+2){1'b0}}};
        w_next            = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (bus.mem_data_valid_i) begin
          w_beat              = 1'b1;
          bus.cache_write_o   = 1'b1;
          bus.cache_enable_o  = 4'b0001;
          bus.cache_data_o    = bus.mem_data_i;
          bus.cache_address_o = {r_addr[31:OFS+2], r_cnt, 2'b00};
          // tag/valid only land with the last word, so an aborted
          // fill never leaves a valid partial block
          if (r_cnt == OFS'(BLOCK_WORDS - 1)) begin
            bus.cache_enable_o = 4'b1111;
            bus.cache_valid_o  = 1'b1;
            w_next             = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        bus.load_valid_o = 1'b1;
        bus.load_data_o  = align(r_word, r_addr[1:0],
                                 r_width, r_signed);
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_unit_cache_control.sv
// Scoreboard bench for the read-side cache controller: directed
// loads, a memory/eviction responder and a decoupled monitor.
module tb_load_unit_cache_control;
  localparam int EV_HOLD = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  load_unit_cache_control_if lu();

  load_unit_cache_control #(
    .PORT_WIDTH(32),
    .BLOCK_WORDS(4),
    .INDEX_BITS(8)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(lu.slave)
  );

  typedef struct {
    logic [31:0] data;
    bit          lat;
  } rsp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  en;
    logic        v;
    logic        dty;
  } wr_t;

  rsp_t        q_rsp[$];
  wr_t         q_wr[$];
  logic [31:0] q_mem[$];
  logic [31:0] q_ev[$];
  int          q_acc[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rsp = 0;
  int          n_exp = 0;
  int          cyc = 0;
  logic [31:0] mem_base = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input logic [31:0] d, input bit lat);
    rsp_t r;
    r.data = d;
    r.lat  = lat;
    q_rsp.push_back(r);
    n_exp++;
  endtask

  task automatic push_fill(input logic [31:0] addr,
                           input logic [31:0] base,
                           input int nbeats);
    wr_t w;
    for (int i = 0; i < nbeats; i++) begin
      w.a   = {addr[31:4], 2'(i), 2'b00};
      w.d   = base + 32'(i);
      w.en  = (i == 3) ? 4'b1111 : 4'b0001;
      w.v   = (i == 3);
      w.dty = 1'b0;
      q_wr.push_back(w);
    end
    q_mem.push_back({addr[31:4], 4'h0});
  endtask

  // monitor: every DUT output event pops and checks an expectation
  initial begin
    rsp_t r;
    wr_t  w;
    int   a;
    int   ev_run;
    ev_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_acc.delete();
        ev_run = 0;
      end else begin
        if (lu.idle_o && lu.load_req_i) q_acc.push_back(cyc);
        if (lu.load_valid_o) begin
          if (q_rsp.size() == 0) begin
            check("unexpected load_valid", 1, 0);
          end else begin
            r = q_rsp.pop_front();
            a = (q_acc.size() != 0) ? q_acc.pop_front() : -1;
            check("load_data", lu.load_data_o, r.data);
            if (r.lat) check("hit latency", cyc - a, 1);
            n_rsp++;
          end
        end
        if (lu.cache_write_o) begin
          if (q_wr.size() == 0) begin
            check("unexpected cache write", 1, 0);
          end else begin
            w = q_wr.pop_front();
            check("cache write",
                  {lu.cache_address_o, lu.cache_data_o,
                   lu.cache_enable_o, lu.cache_valid_o,
                   lu.cache_dirty_o}, w);
          end
        end
        if (lu.evict_req_o) begin
          if (ev_run == 0) begin
            if (q_ev.size() == 0)
              check("unexpected evict_req", 1, 0);
            else
              check("evict_address", lu.evict_address_o,
                    q_ev.pop_front());
          end
          ev_run++;
        end else if (ev_run != 0) begin
          check("evict hold cycles", ev_run, EV_HOLD);
          ev_run = 0;
        end
        if (lu.mem_req_o) begin
          check("mem_req during evict", lu.evict_req_o, 0);
          if (q_mem.size() == 0)
            check("unexpected mem_req", 1, 0);
          else
            check("mem_address", lu.mem_address_o,
                  q_mem.pop_front());
        end
      end
    end
  end

  // memory responder: four ascending words with gap cycles
  initial begin
    lu.mem_data_valid_i = 1'b0;
    lu.mem_data_i       = '0;
    forever begin
      @(negedge clk);
      if (lu.mem_req_o) begin
        for (int i = 0; i < 4; i++) begin
          if (i == 1 || i == 3) begin
            @(posedge clk); #1;
            lu.mem_data_valid_i = 1'b0;
          end
          @(posedge clk); #1;
          lu.mem_data_valid_i = 1'b1;
          lu.mem_data_i       = mem_base + 32'(i);
        end
        @(posedge clk); #1;
        lu.mem_data_valid_i = 1'b0;
        lu.mem_data_i       = '0;
      end
    end
  end

  // eviction responder: done in the EV_HOLD-th request cycle
  initial begin
    int n;
    n = 0;
    lu.evict_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (lu.evict_req_o) begin
        n++;
        if (n == EV_HOLD) lu.evict_done_i = 1'b1;
      end else begin
        n = 0;
      end
      @(posedge clk); #1;
      lu.evict_done_i = 1'b0;
    end
  end

  task automatic set_in(input logic [31:0] addr,
                        input logic [1:0] w, input logic s,
                        input logic hit, input logic dty,
                        input logic [31:0] cd);
    lu.load_address_i = addr;
    lu.load_width_i   = w;
    lu.load_signed_i  = s;
    lu.cache_hit_i    = hit;
    lu.cache_dirty_i  = dty;
    lu.cache_data_i   = cd;
  endtask

  task automatic issue(input logic [31:0] addr,
                       input logic [1:0] w, input logic s,
                       input logic hit, input logic dty,
                       input logic [31:0] cd, input int hold);
    int t;
    t = 0;
    @(posedge clk); #1;
    set_in(addr, w, s, hit, dty, cd);
    lu.load_req_i = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!lu.idle_o && t < 200);
    if (!lu.idle_o) check("accept timeout", 0, 1);
    @(posedge clk); #1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    lu.load_req_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (n_rsp < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (n_rsp < n) check("response timeout", n_rsp, n);
  endtask

  function automatic logic any_out();
    return |{lu.load_data_o, lu.load_valid_o,
             lu.cache_read_o, lu.cache_write_o,
             lu.cache_address_o, lu.cache_data_o,
             lu.cache_valid_o, lu.cache_dirty_o,
             lu.cache_enable_o, lu.evict_req_o,
             lu.evict_address_o, lu.mem_req_o,
             lu.mem_address_o};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [1:0]  w;
    logic        s;
    logic [31:0] cd;
    logic [31:0] exp;
  } hit_t;

  hit_t hits[7] = '{
    '{32'h0000_1003, 2'b00, 1'b1, 32'h80FF_FF7F, 32'hFFFF_FF80},
    '{32'h0000_1002, 2'b01, 1'b0, 32'hBEEF_1234, 32'h0000_BEEF},
    '{32'h0000_1002, 2'b01, 1'b1, 32'hBEEF_1234, 32'hFFFF_BEEF},
    '{32'h0000_1001, 2'b01, 1'b1, 32'h0000_8001, 32'hFFFF_8001},
    '{32'h0000_2005, 2'b00, 1'b0, 32'h0000_AB00, 32'h0000_00AB},
    '{32'h0000_2004, 2'b10, 1'b1, 32'h8765_4321, 32'h8765_4321},
    '{32'h0000_0FFE, 2'b00, 1'b1, 32'h00FF_0000, 32'hFFFF_FFFF}
  };

  initial begin
    int t;
    int nw;
    int t1;
    int acc;
    lu.load_req_i = 1'b0;
    set_in('0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    #1 rst_n = 1'b0;
    #2;
    check("outputs zero in reset", any_out(), 0);
    check("idle_o in reset", lu.idle_o, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (hits[i]) begin
      push_rsp(hits[i].exp, 1'b1);
      issue(hits[i].a, hits[i].w, hits[i].s, 1'b1, 1'b0,
            hits[i].cd, 0);
      wait_rsp(n_exp);
    end

    mem_base = 32'h0000_00A0;
    push_fill(32'h0000_5A38, mem_base, 4);
    push_rsp(32'h0000_00A2, 1'b0);
    issue(32'h0000_5A38, 2'b10, 1'b0, 1'b0, 1'b0,
          32'hDEAD_0000, 0);
    wait_rsp(n_exp);

    mem_base = 32'hCAFE_0080;
    q_ev.push_back(32'h0000_0670);
    push_fill(32'h1234_567A, mem_base, 4);
    push_rsp(32'hFFFF_CAFE, 1'b0);
    issue(32'h1234_567A, 2'b01, 1'b1, 1'b0, 1'b1,
          32'h0, 0);
    wait_rsp(n_exp);

    mem_base = 32'h7000_0010;
    push_fill(32'h0000_0A4C, mem_base, 4);
    push_rsp(32'h7000_0013, 1'b0);
    issue(32'h0000_0A4C, 2'b11, 1'b0, 1'b0, 1'b0,
          32'h0, 3);
    wait_rsp(n_exp);
    repeat (10) @(negedge clk);

    push_rsp(32'h1122_3344, 1'b1);
    push_rsp(32'h1122_3344, 1'b1);
    @(posedge clk); #1;
    set_in(32'h0000_3000, 2'b10, 1'b0, 1'b1, 1'b0,
           32'h1122_3344);
    lu.load_req_i = 1'b1;
    acc = 0;
    t = 0;
    t1 = 0;
    while (acc < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (lu.idle_o) begin
        acc++;
        if (acc == 1) t1 = t;
      end
    end
    check("back-to-back accepts", acc, 2);
    check("back-to-back spacing", t - t1, 2);
    @(posedge clk); #1;
    lu.load_req_i = 1'b0;
    wait_rsp(n_exp);

    mem_base = 32'h0000_0055;
    push_fill(32'h0000_0010, mem_base, 3);
    void'(q_mem.pop_back());
    q_mem.push_back(32'h0000_0010);
    issue(32'h0000_0010, 2'b10, 1'b0, 1'b0, 1'b0,
          32'h0, 0);
    nw = 0;
    t = 0;
    while (nw < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (lu.cache_write_o) nw++;
    end
    check("writes before reset", nw, 3);
    #2 rst_n = 1'b0;
    #1;
    check("outputs zero mid-fill reset", any_out(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_o after reset", lu.idle_o, 1);
    repeat (6) @(negedge clk);

    push_rsp(32'h0BAD_F00D, 1'b1);
    issue(32'h0000_0010, 2'b10, 1'b0, 1'b1, 1'b0,
          32'h0BAD_F00D, 0);
    wait_rsp(n_exp);
    repeat (5) @(negedge clk);

    check("pending responses", q_rsp.size(), 0);
    check("pending writes", q_wr.size(), 0);
    check("pending mem_req", q_mem.size(), 0);
    check("pending evict", q_ev.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
